// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// writeback and drives every datapath enable and mux select from the current state.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_write,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t cur_state, next_state, dec_state;
  logic   pc_write, branch;

  assign state = cur_state;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; combinational blocks below use blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) cur_state <= S_FETCH;
    else     cur_state <= next_state;
  end

  // While in reset the selects present FETCH values even if the register still
  // holds a mid-instruction state.
  assign dec_state = rst ? S_FETCH : cur_state;

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    next_state = S_FETCH;
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    illegal_op = 1'b0;

    case (dec_state)
      S_FETCH: begin
        alu_src_b  = 2'b01;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        next_state = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default: begin
            next_state = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        next_state = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        next_state = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase

    // Reset aborts the instruction: no write or PC update may slip through.
    if (rst) begin
      pc_write   = 1'b0;
      branch     = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign pc_en = pc_write | (branch & zero);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected state/control words are
// queued as stimulus is applied and checked against the DUT half a cycle later.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_en;
    logic       ir_write;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
  } ctrl_t;

  typedef struct packed {
    logic [3:0] st;
    ctrl_t      c;
  } exp_t;

  //                                  pce irw mw iord rw rd m2r a  b      op     pcs    ill
  localparam ctrl_t C_RESET      = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam ctrl_t C_FETCH_WAIT = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam ctrl_t C_FETCH_RDY  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam ctrl_t C_DECODE     = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
  localparam ctrl_t C_DECODE_ILL = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1};
  localparam ctrl_t C_MEMADR     = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam ctrl_t C_MEMRD      = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam ctrl_t C_MEMWB      = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam ctrl_t C_MEMWR      = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam ctrl_t C_EXEC       = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
  localparam ctrl_t C_ALUWB      = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam ctrl_t C_BR_TAKEN   = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
  localparam ctrl_t C_BR_NOT     = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
  localparam ctrl_t C_ADDIEX     = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam ctrl_t C_ADDIWB     = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam ctrl_t C_JUMP       = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0};

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, ir_write, mem_write, iord, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  exp_t  sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  string tag;

  multicycle_control dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .iord       (iord),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Queue the expectation for the cycle just driven, compare it mid-cycle, then
  // advance to just after the next rising edge.
  task automatic step(input logic [3:0] st, input ctrl_t c);
    exp_t  e;
    ctrl_t obs;
    sb.push_back('{st: st, c: c});
    @(negedge clk);
    e   = sb.pop_front();
    obs = '{pc_en, ir_write, mem_write, iord, reg_write, reg_dst, mem_to_reg,
            alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};
    n_cmp++;
    assert (state === e.st) else begin
      n_bad++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state, e.st);
    end
    n_cmp++;
    assert (obs === e.c) else begin
      n_bad++;
      $error("FAIL %s ctrl: observed %b expected %b", tag, obs, e.c);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    opcode    = 6'b100011;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;

    tag = "reset";
    step(4'd0, C_RESET);
    step(4'd0, C_RESET);
    rst = 1'b0;

    tag = "lw";
    step(4'd0, C_FETCH_RDY);
    step(4'd1, C_DECODE);
    step(4'd2, C_MEMADR);
    step(4'd3, C_MEMRD);
    step(4'd4, C_MEMWB);

    tag = "lw_wait";
    mem_ready = 1'b0;
    step(4'd0, C_FETCH_WAIT);
    mem_ready = 1'b1;
    step(4'd0, C_FETCH_RDY);
    step(4'd1, C_DECODE);
    step(4'd2, C_MEMADR);
    mem_ready = 1'b0;
    step(4'd3, C_MEMRD);
    mem_ready = 1'b1;
    step(4'd3, C_MEMRD);
    step(4'd4, C_MEMWB);

    tag = "sw_stall";
    opcode = 6'b101011;
    step(4'd0, C_FETCH_RDY);
    step(4'd1, C_DECODE);
    step(4'd2, C_MEMADR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(4'd5, C_MEMWR);
    mem_ready = 1'b1;
    step(4'd5, C_MEMWR);

    tag = "beq_taken";
    opcode = 6'b000100;
    zero   = 1'b1;
    step(4'd0, C_FETCH_RDY);
    step(4'd1, C_DECODE);
    step(4'd8, C_BR_TAKEN);

    tag = "beq_not";
    zero = 1'b0;
    step(4'd0, C_FETCH_RDY);
    step(4'd1, C_DECODE);
    step(4'd8, C_BR_NOT);

    tag = "rtype";
    opcode = 6'b000000;
    step(4'd0, C_FETCH_RDY);
    step(4'd1, C_DECODE);
    step(4'd6, C_EXEC);
    step(4'd7, C_ALUWB);

    tag = "addi";
    opcode = 6'b001000;
    step(4'd0, C_FETCH_RDY);
    step(4'd1, C_DECODE);
    step(4'd9, C_ADDIEX);
    step(4'd10, C_ADDIWB);

    tag = "jump";
    opcode = 6'b000010;
    step(4'd0, C_FETCH_RDY);
    step(4'd1, C_DECODE);
    step(4'd11, C_JUMP);

    tag = "illegal";
    opcode = 6'b111111;
    step(4'd0, C_FETCH_RDY);
    step(4'd1, C_DECODE_ILL);
    step(4'd0, C_FETCH_RDY);

    tag = "rst_in_memwr";
    opcode = 6'b101011;
    step(4'd1, C_DECODE);
    step(4'd2, C_MEMADR);
    mem_ready = 1'b0;
    step(4'd5, C_MEMWR);
    rst = 1'b1;
    step(4'd5, C_RESET);
    rst       = 1'b0;
    mem_ready = 1'b1;
    step(4'd0, C_FETCH_RDY);
    step(4'd1, C_DECODE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
